// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller: RV32I opcodes, FSM state
// encodings and forwarding-select codes used by the EX-stage operand muxes.
package hazard_ctrl_pkg;

   localparam logic [6:0] OpLui    = 7'b0110111;
   localparam logic [6:0] OpAuipc  = 7'b0010111;
   localparam logic [6:0] OpJal    = 7'b1101111;
   localparam logic [6:0] OpJalr   = 7'b1100111;
   localparam logic [6:0] OpBranch = 7'b1100011;
   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpAriI   = 7'b0010011;
   localparam logic [6:0] OpAriR   = 7'b0110011;

   typedef enum logic [1:0] {
      StRun    = 2'd0,
      StLstall = 2'd1,
      StFlush  = 2'd2
   } hz_state_e;

   typedef enum logic [1:0] {
      FwdRf = 2'd0,
      FwdEx = 2'd1,
      FwdWb = 2'd2
   } fwd_sel_e;

   // EX wins over WB; a load still in EX cannot forward (that case stalls instead).
   function automatic logic [1:0] fwd_select(input logic       used,
                                             input logic [4:0] adr,
                                             input logic       ex_wen,
                                             input logic       ex_load,
                                             input logic [4:0] ex_rd,
                                             input logic       wb_wen,
                                             input logic [4:0] wb_rd);
      if (!used || adr == 5'd0) return FwdRf;
      if (ex_wen && !ex_load && adr == ex_rd) return FwdEx;
      if (wb_wen && adr == wb_rd) return FwdWb;
      return FwdRf;
   endfunction

endpackage

// File: rtl/hazard_ctrl_src_use_decode.sv
// Opcode classifier: which source registers an instruction reads, whether it writes rd,
// and whether it is a load.
module src_use_decode
   import hazard_ctrl_pkg::*;
(
   input  logic [6:0] opcode,
   output logic       use_rs1,
   output logic       use_rs2,
   output logic       writes_rd,
   output logic       is_load
);

   // Unknown opcodes are treated conservatively: both sources read, rd written.
   always_comb begin
      use_rs1   = 1'b1;
      use_rs2   = 1'b1;
      writes_rd = 1'b1;
      case (opcode)
         OpLui, OpAuipc, OpJal: begin
            use_rs1 = 1'b0;
            use_rs2 = 1'b0;
         end
         OpJalr, OpLoad, OpAriI: use_rs2 = 1'b0;
         OpBranch, OpStore:      writes_rd = 1'b0;
         default: ;
      endcase
      is_load = (opcode == OpLoad);
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 3-stage core: load-use stall, redirect flush, memory freeze and
// operand forwarding selects, all resolved combinationally against the EX/WB scoreboard.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int unsigned LOAD_LAT = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       mem_stall,
   input  logic       id_valid,
   input  logic [6:0] id_opcode,
   input  logic [4:0] id_rd,
   input  logic [4:0] id_adr1,
   input  logic [4:0] id_adr2,
   input  logic       ex_redirect,
   output logic       pc_stall,
   output logic       if_id_stall,
   output logic       id_bubble,
   output logic       flush_if_id,
   output logic [1:0] fwd_sel_a,
   output logic [1:0] fwd_sel_b
);

   localparam int unsigned     CntW    = $clog2(LOAD_LAT + 1);
   localparam logic [CntW-1:0] CntInit = CntW'(LOAD_LAT - 1);

   hz_state_e       state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   logic       ex_wen_q, ex_load_q, wb_wen_q;
   logic [4:0] ex_rd_q, wb_rd_q;

   logic use_rs1, use_rs2, writes_rd, is_load;
   logic id_wen, hz;

   src_use_decode u_src_use_decode (
      .opcode    (id_opcode),
      .use_rs1   (use_rs1),
      .use_rs2   (use_rs2),
      .writes_rd (writes_rd),
      .is_load   (is_load)
   );

   assign id_wen = id_valid & writes_rd & (id_rd != 5'd0);

   // ex_wen already implies ex_rd != x0, so an unused x0 source can never match here.
   assign hz = id_valid & ex_wen_q & ex_load_q &
               ((use_rs1 & (id_adr1 == ex_rd_q)) | (use_rs2 & (id_adr2 == ex_rd_q)));

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      pc_stall    = 1'b0;
      if_id_stall = 1'b0;
      id_bubble   = 1'b0;
      flush_if_id = 1'b0;
      if (rst) begin
         state_d = StRun;
      end else if (mem_stall) begin
         pc_stall    = 1'b1;
         if_id_stall = 1'b1;
      end else begin
         unique case (state_q)
            StRun: begin
               if (ex_redirect) begin
                  flush_if_id = 1'b1;
                  id_bubble   = 1'b1;
                  state_d     = StFlush;
               end else if (hz) begin
                  pc_stall    = 1'b1;
                  if_id_stall = 1'b1;
                  id_bubble   = 1'b1;
                  cnt_d       = CntInit;
                  state_d     = (CntInit != '0) ? StLstall : StRun;
               end
            end
            StLstall: begin
               if (ex_redirect) begin
                  flush_if_id = 1'b1;
                  id_bubble   = 1'b1;
                  cnt_d       = '0;
                  state_d     = StFlush;
               end else if (cnt_q != '0) begin
                  pc_stall    = 1'b1;
                  if_id_stall = 1'b1;
                  id_bubble   = 1'b1;
                  cnt_d       = cnt_q - CntW'(1);
               end else begin
                  state_d = StRun;
               end
            end
            StFlush: begin
               // Kills the wrong-path word already fetched by the synchronous imem.
               flush_if_id = 1'b1;
               id_bubble   = 1'b1;
               state_d     = ex_redirect ? StFlush : StRun;
            end
            default: state_d = StRun;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StRun;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_wen_q  <= 1'b0;
         ex_load_q <= 1'b0;
         ex_rd_q   <= 5'd0;
         wb_wen_q  <= 1'b0;
         wb_rd_q   <= 5'd0;
      end else if (!mem_stall) begin
         wb_wen_q  <= ex_wen_q;
         wb_rd_q   <= ex_rd_q;
         ex_wen_q  <= id_wen & ~id_bubble;
         ex_load_q <= id_valid & is_load & ~id_bubble;
         ex_rd_q   <= id_rd;
      end
   end

   always_comb begin
      fwd_sel_a = FwdRf;
      fwd_sel_b = FwdRf;
      if (!rst) begin
         fwd_sel_a = fwd_select(use_rs1, id_adr1, ex_wen_q, ex_load_q, ex_rd_q, wb_wen_q,
                                wb_rd_q);
         fwd_sel_b = fwd_select(use_rs2, id_adr2, ex_wen_q, ex_load_q, ex_rd_q, wb_wen_q,
                                wb_rd_q);
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (LOAD_LAT 1 and 3) on shared stimulus, checked every
// cycle against a remaining-cycles pipeline model plus directed literal expectations.
module tb_hazard_ctrl;

   localparam logic [6:0] LUI    = 7'b0110111;
   localparam logic [6:0] AUIPC  = 7'b0010111;
   localparam logic [6:0] JAL    = 7'b1101111;
   localparam logic [6:0] JALR   = 7'b1100111;
   localparam logic [6:0] BRANCH = 7'b1100011;
   localparam logic [6:0] LOAD   = 7'b0000011;
   localparam logic [6:0] STORE  = 7'b0100011;
   localparam logic [6:0] ARI_I  = 7'b0010011;
   localparam logic [6:0] ARI_R  = 7'b0110011;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       mem_stall = 1'b0;
   logic       id_valid = 1'b0;
   logic       ex_redirect = 1'b0;
   logic [6:0] id_opcode = 7'd0;
   logic [4:0] id_rd = 5'd0, id_adr1 = 5'd0, id_adr2 = 5'd0;

   logic       w_pc[2], w_ifid[2], w_bub[2], w_fl[2];
   logic [1:0] w_fa[2], w_fb[2];

   int checks = 0;
   int failures = 0;
   int nst;

   // Model: in-flight EX/WB writers plus counts of stall/flush cycles still owed.
   bit         m_ex_w[2], m_ex_ld[2], m_wb_w[2];
   logic [4:0] m_ex_rd[2], m_wb_rd[2];
   int         m_stall_left[2], m_flush_left[2];
   bit         e_pc, e_bub, e_fl, e_hz, e_wen;
   int         e_fa, e_fb, lat;
   logic [1:0] e_use;

   always #5 clk = ~clk;

   hazard_ctrl #(.LOAD_LAT(1)) dut1 (
      .clk(clk), .rst(rst), .mem_stall(mem_stall), .id_valid(id_valid),
      .id_opcode(id_opcode), .id_rd(id_rd), .id_adr1(id_adr1), .id_adr2(id_adr2),
      .ex_redirect(ex_redirect), .pc_stall(w_pc[0]), .if_id_stall(w_ifid[0]),
      .id_bubble(w_bub[0]), .flush_if_id(w_fl[0]), .fwd_sel_a(w_fa[0]), .fwd_sel_b(w_fb[0])
   );

   hazard_ctrl #(.LOAD_LAT(3)) dut3 (
      .clk(clk), .rst(rst), .mem_stall(mem_stall), .id_valid(id_valid),
      .id_opcode(id_opcode), .id_rd(id_rd), .id_adr1(id_adr1), .id_adr2(id_adr2),
      .ex_redirect(ex_redirect), .pc_stall(w_pc[1]), .if_id_stall(w_ifid[1]),
      .id_bubble(w_bub[1]), .flush_if_id(w_fl[1]), .fwd_sel_a(w_fa[1]), .fwd_sel_b(w_fb[1])
   );

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
      end
   endtask

   // {reads rs1, reads rs2}
   function automatic logic [1:0] uses(input logic [6:0] op);
      case (op)
         LUI, AUIPC, JAL:     return 2'b00;
         JALR, LOAD, ARI_I:   return 2'b10;
         default:             return 2'b11;
      endcase
   endfunction

   function automatic int exp_fwd(input int k, input bit used, input logic [4:0] adr);
      if (!used || adr == 5'd0) return 0;
      if (m_ex_w[k] && !m_ex_ld[k] && m_ex_rd[k] == adr) return 1;
      if (m_wb_w[k] && m_wb_rd[k] == adr) return 2;
      return 0;
   endfunction

   task automatic model_reset(input int k);
      m_ex_w[k] = 0; m_ex_ld[k] = 0; m_ex_rd[k] = 0; m_wb_w[k] = 0; m_wb_rd[k] = 0;
      m_stall_left[k] = 0; m_flush_left[k] = 0;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic put(input bit v, input logic [6:0] op, input logic [4:0] rd,
                      input logic [4:0] a1, input logic [4:0] a2);
      id_valid = v; id_opcode = op; id_rd = rd; id_adr1 = a1; id_adr2 = a2;
   endtask

   task automatic nop();
      put(0, 7'd0, 5'd0, 5'd0, 5'd0);
   endtask

   initial begin
      model_reset(0);
      model_reset(1);
      fork
         forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
               lat = (k == 0) ? 1 : 3;
               e_pc = 0; e_bub = 0; e_fl = 0;
               e_use = uses(id_opcode);
               e_wen = id_valid && id_opcode != BRANCH && id_opcode != STORE && id_rd != 0;
               e_hz = id_valid && m_ex_w[k] && m_ex_ld[k] &&
                      ((e_use[1] && id_adr1 == m_ex_rd[k]) || (e_use[0] && id_adr2 == m_ex_rd[k]));
               e_fa = exp_fwd(k, e_use[1], id_adr1);
               e_fb = exp_fwd(k, e_use[0], id_adr2);
               if (rst) begin
                  e_fa = 0; e_fb = 0;
                  model_reset(k);
               end else if (mem_stall) begin
                  e_pc = 1;
               end else begin
                  if (ex_redirect) begin
                     e_fl = 1; e_bub = 1; m_flush_left[k] = 1; m_stall_left[k] = 0;
                  end else if (m_flush_left[k] > 0) begin
                     e_fl = 1; e_bub = 1; m_flush_left[k]--;
                  end else if (m_stall_left[k] > 0) begin
                     e_pc = 1; e_bub = 1; m_stall_left[k]--;
                  end else if (e_hz) begin
                     e_pc = 1; e_bub = 1; m_stall_left[k] = lat - 1;
                  end
                  m_wb_w[k] = m_ex_w[k];
                  m_wb_rd[k] = m_ex_rd[k];
                  m_ex_w[k] = e_wen && !e_bub;
                  m_ex_ld[k] = id_valid && id_opcode == LOAD && !e_bub;
                  m_ex_rd[k] = id_rd;
               end
               chk($sformatf("L%0d pc_stall", lat), int'(w_pc[k]), int'(e_pc));
               chk($sformatf("L%0d if_id_stall", lat), int'(w_ifid[k]), int'(e_pc));
               chk($sformatf("L%0d id_bubble", lat), int'(w_bub[k]), int'(e_bub));
               chk($sformatf("L%0d flush_if_id", lat), int'(w_fl[k]), int'(e_fl));
               chk($sformatf("L%0d fwd_sel_a", lat), int'(w_fa[k]), e_fa);
               chk($sformatf("L%0d fwd_sel_b", lat), int'(w_fb[k]), e_fb);
            end
         end
         begin
            // Reset dominates even a concurrent freeze and redirect.
            mem_stall = 1; ex_redirect = 1;
            #2;
            chk("reset pc_stall", int'(w_pc[0]), 0);
            chk("reset flush", int'(w_fl[1]), 0);
            chk("reset bubble", int'(w_bub[0]), 0);
            cyc(); cyc();
            rst = 0; mem_stall = 0; ex_redirect = 0; nop();

            // Load-use
            cyc(); put(1, LOAD, 5, 1, 0); settle();
            chk("lw no stall", int'(w_pc[0]), 0);
            chk("lw fwd_a", int'(w_fa[0]), 0);
            cyc(); put(1, ARI_R, 6, 5, 2); settle();
            chk("L1 load-use pc_stall", int'(w_pc[0]), 1);
            chk("L1 load-use if_id_stall", int'(w_ifid[0]), 1);
            chk("L1 load-use bubble", int'(w_bub[0]), 1);
            chk("L3 load-use pc_stall", int'(w_pc[1]), 1);
            cyc(); settle();
            chk("L1 after stall pc", int'(w_pc[0]), 0);
            chk("L1 after stall bubble", int'(w_bub[0]), 0);
            chk("L1 after stall fwd_a", int'(w_fa[0]), 2);
            chk("L1 after stall fwd_b", int'(w_fb[0]), 0);
            chk("L3 stall cycle 2", int'(w_pc[1]), 1);
            cyc(); nop(); settle();
            chk("L3 stall cycle 3", int'(w_pc[1]), 1);
            cyc(); settle();
            chk("L3 stall ends", int'(w_pc[1]), 0);
            cyc(); cyc();

            // ALU back-to-back
            cyc(); put(1, ARI_I, 5, 0, 0); settle();
            chk("addi fwd_a", int'(w_fa[0]), 0);
            cyc(); put(1, ARI_R, 7, 5, 5); settle();
            chk("sub fwd_a", int'(w_fa[0]), 1);
            chk("sub fwd_b", int'(w_fb[0]), 1);
            chk("sub L3 fwd_a", int'(w_fa[1]), 1);
            chk("sub no stall", int'(w_pc[0]), 0);
            cyc(); put(1, ARI_R, 8, 5, 0); settle();
            chk("or fwd_a", int'(w_fa[0]), 2);
            chk("or fwd_b", int'(w_fb[0]), 0);
            cyc(); nop(); cyc();

            // Redirect pulses
            cyc(); ex_redirect = 1; settle();
            chk("redir1 flush", int'(w_fl[0]), 1);
            chk("redir1 bubble", int'(w_bub[0]), 1);
            chk("redir1 pc_stall", int'(w_pc[0]), 0);
            cyc(); ex_redirect = 0; settle();
            chk("redir1 flush cyc2", int'(w_fl[0]), 1);
            cyc(); settle();
            chk("redir1 flush done", int'(w_fl[0]), 0);
            chk("redir1 bubble done", int'(w_bub[0]), 0);
            cyc(); ex_redirect = 1; settle();
            chk("redir2 flush", int'(w_fl[0]), 1);
            cyc(); settle();
            chk("redir in FLUSH", int'(w_fl[1]), 1);
            cyc(); ex_redirect = 0; settle();
            chk("redir2 tail", int'(w_fl[0]), 1);
            cyc(); settle();
            chk("redir2 done", int'(w_fl[1]), 0);

            // Redirect during a 3-cycle stall
            cyc(); put(1, LOAD, 5, 1, 0);
            cyc(); put(1, ARI_R, 6, 5, 2); settle();
            chk("L3 abort stall1", int'(w_pc[1]), 1);
            cyc(); ex_redirect = 1; settle();
            chk("L3 abort pc_stall", int'(w_pc[1]), 0);
            chk("L3 abort if_id_stall", int'(w_ifid[1]), 0);
            chk("L3 abort flush", int'(w_fl[1]), 1);
            cyc(); ex_redirect = 0; nop(); settle();
            chk("L3 abort flush2", int'(w_fl[1]), 1);
            cyc(); settle();
            chk("L3 abort flush end", int'(w_fl[1]), 0);
            chk("L3 abort no stall", int'(w_pc[1]), 0);
            cyc();

            // x0 never hazards or forwards
            cyc(); put(1, LOAD, 0, 1, 0);
            cyc(); put(1, ARI_R, 1, 0, 0); settle();
            chk("x0 no stall", int'(w_pc[0]), 0);
            chk("x0 fwd_a", int'(w_fa[0]), 0);
            chk("x0 fwd_b", int'(w_fb[0]), 0);
            chk("x0 L3 no stall", int'(w_pc[1]), 0);

            // Freeze for 3 cycles inside a LOAD_LAT=3 stall
            cyc(); put(1, LOAD, 5, 1, 0);
            cyc(); put(1, ARI_R, 6, 5, 2); settle();
            nst = int'(w_pc[1]);
            for (int i = 0; i < 3; i++) begin
               cyc(); mem_stall = 1; settle();
               chk("freeze bubble", int'(w_bub[1]), 0);
               chk("freeze flush", int'(w_fl[1]), 0);
               if (w_pc[1]) nst++;
            end
            for (int i = 0; i < 5; i++) begin
               cyc(); mem_stall = 0; nop(); settle();
               if (w_pc[1]) nst++;
            end
            chk("L3 frozen stall total", nst, 6);

            // Reset in the middle of a stall
            cyc(); put(1, LOAD, 5, 1, 0);
            cyc(); put(1, ARI_R, 6, 5, 2);
            cyc(); settle();
            chk("pre-reset stall", int'(w_pc[1]), 1);
            #1; rst = 1; #1;
            chk("async reset pc_stall", int'(w_pc[1]), 0);
            chk("async reset if_id_stall", int'(w_ifid[1]), 0);
            chk("async reset bubble", int'(w_bub[1]), 0);
            chk("async reset fwd_a", int'(w_fa[1]), 0);
            cyc(); rst = 0; settle();
            chk("post-reset L3 pc", int'(w_pc[1]), 0);
            chk("post-reset L3 fwd_a", int'(w_fa[1]), 0);
            chk("post-reset L1 fwd_a", int'(w_fa[0]), 0);
            cyc(); nop(); cyc(); cyc();
         end
      join_any
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
